sign_extend_stream: RTL and testbench
=====================================

Name: sign_extend_stream

Overview:
- Parametrised successor to the fixed 3-to-8 sign extender, used in the datapath to widen immediates and offsets.
- Converts an IN_WIDTH operand to OUT_WIDTH using a per-transaction mode: sign-extend or zero-extend.
- Valid/ready streaming on both sides, with a DEPTH-entry output buffer that absorbs downstream stalls.
- Output is registered with one-cycle latency; no combinational path from input to output or from out_ready to in_ready.

Parameters:
- IN_WIDTH, 3, input operand width; must be >= 1.
- OUT_WIDTH, 8, output width; must be >= IN_WIDTH. If equal, data passes through unchanged.
- DEPTH, 2, number of output buffer entries; must be >= 1.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_sign  input  IN_WIDTH  operand to extend.
- in_mode  input  1  1 = sign-extend, 0 = zero-extend; sampled with in_sign.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_sign  output  OUT_WIDTH  extended value at the buffer head.
- out_neg  output  1  MSB of out_sign at the head entry.
- fifo_level  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Clock and reset: one clock (clock). Reset is asynchronous and active-low (reset_n).
- While reset_n is low:
  - level = 0, read and write pointers = 0.
  - out_valid = 0, out_sign = 0, out_neg = 0, fifo_level = 0.
  - in_ready is forced to 0.
- Reset mid-operation clears all entries immediately. Entries in flight are discarded, not drained.
- Push and pop:
  - Push occurs when in_valid && in_ready at a rising edge.
  - Pop occurs when out_valid && out_ready at a rising edge.
- in_ready = (level != DEPTH), gated by reset_n. It depends only on registered state, never on out_ready.
- Extension, computed at push time and stored:
  - Sign mode: upper OUT_WIDTH-IN_WIDTH bits = in_sign[IN_WIDTH-1].
  - Zero mode: upper bits = 0.
  - Low IN_WIDTH bits always = in_sign.
- Latency: an operand pushed at edge N is visible on out_sign with out_valid = 1 after edge N, if the buffer was empty. There is no bypass path.
- out_valid = (level != 0). out_sign and out_neg show the head entry. They hold stable while out_valid && !out_ready.
- Simultaneous push and pop: level unchanged, both pointers advance. Allowed at any level except full (no push, since in_ready = 0) and empty (no pop).
- Full (level == DEPTH): in_ready = 0. A pop at this edge makes in_ready = 1 in the next cycle.
- Empty: out_valid = 0. out_sign holds its last value and must not be used.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- in_valid while in_ready = 0: no effect. The source must hold its data, per the standard valid/ready rule.
- Ordering: strict FIFO.

Optional Feature:
- Macro: SIGN_EXT_SHIFT_EN.
- Defined:
  - Adds port in_shl (input, 2 bits), sampled with in_sign.
  - The extended value is shifted left by in_shl (0..3) before storage.
  - Bits shifted past OUT_WIDTH-1 are discarded; LSBs are filled with 0.
  - out_neg reflects the post-shift MSB.
- Undefined: the in_shl port does not exist; no shift is applied.

Test Plan (defaults IN_WIDTH=3, OUT_WIDTH=8, DEPTH=2):
- Basic sign extension:
  - in_sign=3'b011, in_mode=1, out_ready=1 -> next cycle out_sign=8'h03, out_neg=0, out_valid=1 for one cycle.
  - in_sign=3'b101, in_mode=1 -> out_sign=8'hFD, out_neg=1.
- Zero extension: in_sign=3'b101, in_mode=0 -> out_sign=8'h05, out_neg=0.
- Back-pressure:
  - Hold out_ready=0 and push 3'b001, 3'b010, 3'b011 on consecutive cycles -> first two accepted, fifo_level=2, in_ready=0, third held.
  - Raise out_ready -> outputs 8'h01, 8'h02, 8'h03 in order, with no loss or duplication.
- Simultaneous push and pop at level 1 with continuous streaming -> fifo_level stays 1, one output per cycle, in-order values.
- Reset mid-operation: fifo_level=2, assert reset_n=0 between edges -> out_valid=0, fifo_level=0 and in_ready=0 immediately; after release in_ready=1 and no stale data appears.
- SIGN_EXT_SHIFT_EN:
  - in_sign=3'b111, in_mode=1, in_shl=2 -> out_sign=8'hFC.
  - in_sign=3'b011, in_mode=0, in_shl=3 -> 8'h18.

Source files
------------

// File: rtl/sign_extend_stream.sv
// rtl/sign_extend_stream.sv - parametrised sign/zero extender with valid/ready stream and output FIFO
// Optional build macro SIGN_EXT_SHIFT_EN adds in_shl, a 0..3 left shift applied before storage.
module sign_extend_stream #(
    parameter int IN_WIDTH  = 3,
    parameter int OUT_WIDTH = 8,
    parameter int DEPTH     = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH-1:0]          in_sign,
    input  logic                         in_mode,
`ifdef SIGN_EXT_SHIFT_EN
    input  logic [1:0]                   in_shl,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_sign,
    output logic                         out_neg,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OUT_WIDTH-1:0] LOW_MASK = OUT_WIDTH'({IN_WIDTH{1'b1}});
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [OUT_WIDTH-1:0] r_data [DEPTH];
    logic [OUT_WIDTH-1:0] r_last;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [LVL_W-1:0]     r_level;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_fill;
    logic [OUT_WIDTH-1:0] w_ext;
    logic [OUT_WIDTH-1:0] w_store;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Upper bits come from the operand MSB only in sign mode; with equal widths the mask is empty.
    assign w_fill = in_mode & in_sign[IN_WIDTH-1];
    assign w_ext  = OUT_WIDTH'(in_sign) | (w_fill ? ~LOW_MASK : '0);

`ifdef SIGN_EXT_SHIFT_EN
    assign w_store = w_ext << in_shl;
`else
    assign w_store = w_ext;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_last  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_store;
                r_wptr         <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_last <= r_data[r_rptr];
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // When empty the head shows the most recently popped value rather than a stale slot.
    assign out_valid  = (r_level != '0);
    assign out_sign   = out_valid ? r_data[r_rptr] : r_last;
    assign out_neg    = out_sign[OUT_WIDTH-1];
    assign in_ready   = reset_n && (r_level != FULL_LVL);
    assign fifo_level = r_level;

endmodule

// File: tb/tb_sign_extend_stream.sv
// tb/tb_sign_extend_stream.sv - directed self-checking bench for sign_extend_stream
module tb_sign_extend_stream;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_sign;
    logic       in_mode;
`ifdef SIGN_EXT_SHIFT_EN
    logic [1:0] in_shl;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sign;
    logic       out_neg;
    logic [1:0] fifo_level;

    int n_checks = 0;
    int n_fails  = 0;

    sign_extend_stream #(.IN_WIDTH(3), .OUT_WIDTH(8), .DEPTH(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_mode    (in_mode),
`ifdef SIGN_EXT_SHIFT_EN
        .in_shl     (in_shl),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_neg    (out_neg),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic m);
        in_valid = v;
        in_sign  = s;
        in_mode  = m;
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'b000, 1'b0);
`ifdef SIGN_EXT_SHIFT_EN
        in_shl = 2'd0;
`endif
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_sign", 32'(out_sign), 32'h00);
        chk("rst_out_neg", 32'(out_neg), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        drive(1'b1, 3'b011, 1'b1);
        tick();
        drive(1'b0, 3'b000, 1'b0);
        chk("sx011_valid", 32'(out_valid), 32'd1);
        chk("sx011_data", 32'(out_sign), 32'h03);
        chk("sx011_neg", 32'(out_neg), 32'd0);
        tick();
        chk("sx011_one_cycle", 32'(out_valid), 32'd0);

        drive(1'b1, 3'b101, 1'b1);
        tick();
        drive(1'b0, 3'b000, 1'b0);
        chk("sx101_data", 32'(out_sign), 32'hFD);
        chk("sx101_neg", 32'(out_neg), 32'd1);
        tick();

        drive(1'b1, 3'b101, 1'b0);
        tick();
        drive(1'b0, 3'b000, 1'b0);
        chk("zx101_data", 32'(out_sign), 32'h05);
        chk("zx101_neg", 32'(out_neg), 32'd0);
        tick();

        // Back-pressure: two accepted, third held at full.
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b1);
        tick();
        chk("bp_level1", 32'(fifo_level), 32'd1);
        drive(1'b1, 3'b010, 1'b1);
        tick();
        chk("bp_level2", 32'(fifo_level), 32'd2);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 3'b011, 1'b1);
        tick();
        chk("bp_held_level", 32'(fifo_level), 32'd2);
        chk("bp_held_head", 32'(out_sign), 32'h01);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_head", 32'(out_sign), 32'h02);
        chk("bp_pop1_level", 32'(fifo_level), 32'd1);
        chk("bp_pop1_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 3'b000, 1'b0);
        chk("bp_pop2_head", 32'(out_sign), 32'h03);
        chk("bp_pop2_level", 32'(fifo_level), 32'd1);
        tick();
        chk("bp_drained_valid", 32'(out_valid), 32'd0);
        chk("bp_drained_level", 32'(fifo_level), 32'd0);

        // Continuous streaming at level 1.
        drive(1'b1, 3'b100, 1'b1);
        tick();
        chk("st0_head", 32'(out_sign), 32'hFC);
        chk("st0_level", 32'(fifo_level), 32'd1);
        drive(1'b1, 3'b110, 1'b1);
        tick();
        chk("st1_head", 32'(out_sign), 32'hFE);
        chk("st1_level", 32'(fifo_level), 32'd1);
        drive(1'b1, 3'b010, 1'b1);
        tick();
        chk("st2_head", 32'(out_sign), 32'h02);
        chk("st2_level", 32'(fifo_level), 32'd1);
        drive(1'b1, 3'b111, 1'b0);
        tick();
        chk("st3_head", 32'(out_sign), 32'h07);
        chk("st3_level", 32'(fifo_level), 32'd1);
        chk("st3_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 3'b000, 1'b0);
        tick();
        chk("st_end_level", 32'(fifo_level), 32'd0);

        // Reset mid-operation with a full buffer.
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b1);
        tick();
        drive(1'b1, 3'b110, 1'b0);
        tick();
        drive(1'b0, 3'b000, 1'b0);
        chk("mr_pre_level", 32'(fifo_level), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_level", 32'(fifo_level), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd0);
        #3;
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mr_rel_in_ready", 32'(in_ready), 32'd1);
        chk("mr_rel_valid", 32'(out_valid), 32'd0);
        tick();
        chk("mr_no_stale_valid", 32'(out_valid), 32'd0);
        chk("mr_no_stale_level", 32'(fifo_level), 32'd0);

`ifdef SIGN_EXT_SHIFT_EN
        drive(1'b1, 3'b111, 1'b1);
        in_shl = 2'd2;
        tick();
        drive(1'b0, 3'b000, 1'b0);
        chk("shl2_data", 32'(out_sign), 32'hFC);
        chk("shl2_neg", 32'(out_neg), 32'd1);
        tick();
        drive(1'b1, 3'b011, 1'b0);
        in_shl = 2'd3;
        tick();
        drive(1'b0, 3'b000, 1'b0);
        in_shl = 2'd0;
        chk("shl3_data", 32'(out_sign), 32'h18);
        chk("shl3_neg", 32'(out_neg), 32'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
